// File: rtl/serial_alu.sv
// Serial-opcode ALU: operand A and operand B arrive on consecutive
// transaction phases, each carrying one opcode bit; the result is registered.
//
// state  | meaning
// IDLE   | waiting for opcode_valid; captures op[0] and A
// HOLD_A | second cycle of A; the sample is ignored
// GET_B  | captures op[1] and B, or aborts if opcode_valid drops
// EXEC   | registers result/overflow and raises done
// DONE   | holds done until opcode_valid falls
module serial_alu #(
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  opcode_valid,
  input  logic                  opcode,
  input  logic [DATA_WIDTH-1:0] data,
  output logic                  done,
  output logic                  overflow,
  output logic [DATA_WIDTH-1:0] result
);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] HOLD_A = 3'd1;
  localparam logic [2:0] GET_B  = 3'd2;
  localparam logic [2:0] EXEC   = 3'd3;
  localparam logic [2:0] DONE   = 3'd4;

  localparam logic [DATA_WIDTH-1:0] ONE = {{(DATA_WIDTH-1){1'b0}}, 1'b1};

  logic [2:0]            state;
  logic [1:0]            op_reg;
  logic [DATA_WIDTH-1:0] a_reg;
  logic [DATA_WIDTH-1:0] b_reg;
  logic [DATA_WIDTH:0]   wide;
  logic [DATA_WIDTH-1:0] alu_res;
  logic                  alu_ovf;

  // The extra MSB of wide is the carry for ADD and the borrow for SUB.
  always_comb begin
    wide    = '0;
    alu_res = '0;
    alu_ovf = 1'b0;
    case (op_reg)
      2'b00: begin
        wide    = {1'b0, a_reg} + {1'b0, b_reg};
        alu_res = wide[DATA_WIDTH-1:0];
        alu_ovf = wide[DATA_WIDTH];
      end
      2'b01: begin
        wide    = {1'b0, a_reg} - {1'b0, b_reg};
        alu_res = wide[DATA_WIDTH-1:0];
        alu_ovf = wide[DATA_WIDTH];
      end
      2'b10: begin
        alu_res = {{(DATA_WIDTH-1){1'b0}}, ^{a_reg, b_reg}};
      end
      default: begin
        if (a_reg > b_reg)
          alu_res = ONE;
        else if (a_reg == b_reg)
          alu_res = '0;
        else
          alu_res = '1;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      op_reg   <= '0;
      a_reg    <= '0;
      b_reg    <= '0;
      done     <= 1'b0;
      overflow <= 1'b0;
      result   <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (opcode_valid) begin
            op_reg[0] <= opcode;
            a_reg     <= data;
            state     <= HOLD_A;
          end
        end
        HOLD_A: begin
          state <= opcode_valid ? GET_B : IDLE;
        end
        GET_B: begin
          if (opcode_valid) begin
            op_reg[1] <= opcode;
            b_reg     <= data;
            state     <= EXEC;
          end else begin
            state <= IDLE;
          end
        end
        EXEC: begin
          result   <= alu_res;
          overflow <= alu_ovf;
          done     <= 1'b1;
          state    <= DONE;
        end
        DONE: begin
          if (!opcode_valid) begin
            done  <= 1'b0;
            state <= IDLE;
          end
        end
        default: begin
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
